// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and defaults for the instruction-fetch front end
package fetch_pkg;
   localparam int INSTR_W = 32;
   localparam int ADDR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_WORD_DEF = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
   localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: holds the in-flight memory word across a stall so release neither drops nor duplicates it
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_stall,
   input  logic               i_redirect,
   input  logic               i_req_valid,
   input  logic [INSTR_W-1:0] i_mem_instr,
   output logic               o_hold_valid,
   output logic [INSTR_W-1:0] o_instr
);
   logic               r_hold_valid;
   logic [INSTR_W-1:0] r_hold_instr;
   // capture only on the first stalled cycle; afterwards the memory is re-reading the next pc
   always_ff @(posedge i_clk) begin
      if (i_reset || i_redirect) r_hold_valid <= 1'b0;
      else if (!i_stall) r_hold_valid <= 1'b0;
      else if (i_req_valid && !r_hold_valid) begin
         r_hold_valid <= 1'b1;
         r_hold_instr <= i_mem_instr;
      end
   end
   assign o_hold_valid = r_hold_valid;
   assign o_instr = r_hold_valid ? r_hold_instr : i_mem_instr;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, redirect/stall handling and IF/ID bundle over a 1-cycle-latency instruction memory
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0]  RESET_PC  = RESET_PC_DEF,
   parameter int                 MEM_BYTES = 1024,
   parameter logic [INSTR_W-1:0] NOP_WORD  = NOP_WORD_DEF
)
(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_stall,
   input  logic               i_redirect_valid,
   input  logic [ADDR_W-1:0]  i_redirect_target,
   output logic [ADDR_W-1:0]  o_imem_addr,
   input  logic [INSTR_W-1:0] i_imem_instr,
   output logic               o_if_valid,
   output logic [INSTR_W-1:0] o_if_instr,
   output logic [ADDR_W-1:0]  o_if_pc,
   output logic [ADDR_W-1:0]  o_if_pc_plus4,
   output logic               o_misalign_err
);
   localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_BYTES - 1);
   logic [ADDR_W-1:0]  r_pc, r_req_pc, r_if_pc, r_if_pc_plus4;
   logic               r_req_valid, r_if_valid, r_misalign;
   logic [INSTR_W-1:0] r_if_instr, w_instr;
   logic               w_hold_valid;
   fetch_skid_buf u_skid (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_stall      (i_stall),
      .i_redirect   (i_redirect_valid),
      .i_req_valid  (r_req_valid),
      .i_mem_instr  (i_imem_instr),
      .o_hold_valid (w_hold_valid),
      .o_instr      (w_instr)
   );
   // reset beats redirect beats stall; otherwise retire the in-flight request and issue the next pc
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pc          <= RESET_PC;
         r_req_pc      <= '0;
         r_req_valid   <= 1'b0;
         r_if_valid    <= 1'b0;
         r_if_instr    <= NOP_WORD;
         r_if_pc       <= '0;
         r_if_pc_plus4 <= PC_STEP;
         r_misalign    <= 1'b0;
      end else if (i_redirect_valid) begin
         r_pc        <= {i_redirect_target[ADDR_W-1:2], 2'b00} & ADDR_MASK;
         r_req_valid <= 1'b0;
         r_if_valid  <= 1'b0;
         r_if_instr  <= NOP_WORD;
         if (|i_redirect_target[1:0]) r_misalign <= 1'b1;
      end else if (!i_stall) begin
         r_if_valid    <= r_req_valid;
         r_if_instr    <= r_req_valid ? w_instr : NOP_WORD;
         r_if_pc       <= r_req_pc;
         r_if_pc_plus4 <= r_req_pc + PC_STEP;
         r_req_pc      <= r_pc;
         r_req_valid   <= 1'b1;
         r_pc          <= (r_pc + PC_STEP) & ADDR_MASK;
      end
   end
   assign o_imem_addr    = r_pc;
   assign o_if_valid     = r_if_valid;
   assign o_if_instr     = r_if_instr;
   assign o_if_pc        = r_if_pc;
   assign o_if_pc_plus4  = r_if_pc_plus4;
   assign o_misalign_err = r_misalign;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed check of fetch latency, stall, redirect, misalign, wrap and reset
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr = '0;
   logic        if_valid;
   logic [31:0] if_instr, if_pc, if_pc_plus4;
   logic        misalign_err;
   logic [31:0] mem [256];
   int          n_tests = 0;
   int          n_fail = 0;

   fetch_unit dut (
      .i_clk             (clk),
      .i_reset           (reset),
      .i_stall           (stall),
      .i_redirect_valid  (redirect_valid),
      .i_redirect_target (redirect_target),
      .o_imem_addr       (imem_addr),
      .i_imem_instr      (imem_instr),
      .o_if_valid        (if_valid),
      .o_if_instr        (if_instr),
      .o_if_pc           (if_pc),
      .o_if_pc_plus4     (if_pc_plus4),
      .o_misalign_err    (misalign_err)
   );

   always #5 clk = ~clk;

   // registered instruction memory: data returns one clock after the address
   always @(posedge clk) imem_instr <= mem[imem_addr[9:2]];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_if(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] instr);
      chk({tag, ".valid"}, {31'b0, if_valid}, {31'b0, v});
      chk({tag, ".instr"}, if_instr, instr);
      if (v) begin
         chk({tag, ".pc"}, if_pc, pc);
         chk({tag, ".pc4"}, if_pc_plus4, pc + 32'd4);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | (i * 4);
      mem[0] = 32'h2108_0000;
      mem[1] = 32'h2129_0001;
      mem[2] = 32'h0109_5024;
      tick();
      tick();
      chk_if("rst", 1'b0, 32'h0, 32'h0);
      chk("rst.pc", if_pc, 32'h0);
      chk("rst.pc4", if_pc_plus4, 32'h4);
      chk("rst.mis", {31'b0, misalign_err}, 32'h0);
      chk("rst.addr", imem_addr, 32'h0);
      reset = 1'b0;
      tick();
      chk_if("lat1", 1'b0, 32'h0, 32'h0);
      chk("lat1.addr", imem_addr, 32'h4);
      tick();
      chk_if("seq0", 1'b1, 32'h0, 32'h2108_0000);
      tick();
      chk_if("seq4", 1'b1, 32'h4, 32'h2129_0001);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_if("stall", 1'b1, 32'h4, 32'h2129_0001);
      end
      stall = 1'b0;
      tick();
      chk_if("rel8", 1'b1, 32'h8, 32'h0109_5024);
      tick();
      chk_if("rel12", 1'b1, 32'hC, 32'hC0DE_000C);
      redirect_valid = 1'b1;
      redirect_target = 32'h1A0;
      tick();
      redirect_valid = 1'b0;
      chk_if("br.n1", 1'b0, 32'h0, 32'h0);
      chk("br.addr", imem_addr, 32'h1A0);
      tick();
      chk_if("br.n2", 1'b0, 32'h0, 32'h0);
      tick();
      chk_if("br.n3", 1'b1, 32'h1A0, 32'hC0DE_01A0);
      tick();
      chk_if("br.n4", 1'b1, 32'h1A4, 32'hC0DE_01A4);
      stall = 1'b1;
      tick();
      redirect_valid = 1'b1;
      tick();
      redirect_valid = 1'b0;
      stall = 1'b0;
      chk_if("brs.n1", 1'b0, 32'h0, 32'h0);
      tick();
      chk_if("brs.n2", 1'b0, 32'h0, 32'h0);
      tick();
      chk_if("brs.n3", 1'b1, 32'h1A0, 32'hC0DE_01A0);
      chk("brs.mis", {31'b0, misalign_err}, 32'h0);
      redirect_valid = 1'b1;
      redirect_target = 32'h1A2;
      tick();
      redirect_valid = 1'b0;
      chk("mis.set", {31'b0, misalign_err}, 32'h1);
      chk("mis.addr", imem_addr, 32'h1A0);
      tick();
      tick();
      chk_if("mis.n3", 1'b1, 32'h1A0, 32'hC0DE_01A0);
      redirect_valid = 1'b1;
      redirect_target = 32'h3FC;
      tick();
      redirect_valid = 1'b0;
      chk("wrap.addr1", imem_addr, 32'h3FC);
      tick();
      chk("wrap.addr2", imem_addr, 32'h0);
      tick();
      chk_if("wrap.hi", 1'b1, 32'h3FC, 32'hC0DE_03FC);
      chk("wrap.hi4", if_pc_plus4, 32'h400);
      chk("mis.sticky", {31'b0, misalign_err}, 32'h1);
      tick();
      chk_if("wrap.lo", 1'b1, 32'h0, 32'h2108_0000);
      stall = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      chk_if("rst2", 1'b0, 32'h0, 32'h0);
      chk("rst2.addr", imem_addr, 32'h0);
      chk("rst2.mis", {31'b0, misalign_err}, 32'h0);
      chk("rst2.pc4", if_pc_plus4, 32'h4);
      reset = 1'b0;
      stall = 1'b0;
      tick();
      chk_if("rst2.lat", 1'b0, 32'h0, 32'h0);
      tick();
      chk_if("rst2.seq0", 1'b1, 32'h0, 32'h2108_0000);
      tick();
      chk_if("rst2.seq4", 1'b1, 32'h4, 32'h2129_0001);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
